// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampled UART receiver with 3-sample majority vote per bit
// Frame: idle high, start 0, DATA_WIDTH bits LSB first, optional parity, one stop bit.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  Par_err,
    output logic                  Stp_err
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                state_q, state_d;
    logic                  sync1_q, sync2_q;
    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [5:0]            presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [2:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic                  rx_s;
    logic [5:0]            half, half_m1, half_p1, bit_last_edge;
    logic                  bit_end;
    logic                  maj_stored;
    logic                  maj_now;
    logic                  stop_bad;

    assign rx_s          = sync2_q;
    assign half          = presc_q >> 1;
    assign half_m1       = half - 6'd1;
    assign half_p1       = half + 6'd1;
    assign bit_last_edge = presc_q - 6'd1;
    assign bit_end       = (edge_cnt_q == bit_last_edge);

    assign maj_stored = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    // The stop decision is taken on the third sample itself, so the live line stands in for samp_q[2].
    assign maj_now    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign stop_bad   = ~maj_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RX_IN;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            presc_q    <= 6'd8;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            samp_q     <= '0;
            shift_q    <= '0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        par_err_d  = par_err_q;
        stp_err_d  = stp_err_q;

        if (state_q != S_IDLE) begin
            edge_cnt_d = edge_cnt_q + 6'd1;
            if (edge_cnt_q == half_m1) samp_d[0] = rx_s;
            if (edge_cnt_q == half)    samp_d[1] = rx_s;
            if (edge_cnt_q == half_p1) samp_d[2] = rx_s;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d    = S_START;
                    edge_cnt_d = '0;
                    par_err_d  = 1'b0;
                    stp_err_d  = 1'b0;
                    presc_d    = (Prescale < 6'd6) ? 6'd8 : Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                end
            end
            S_START: begin
                if (bit_end) begin
                    edge_cnt_d = '0;
                    if (maj_stored) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    edge_cnt_d = '0;
                    shift_d    = {maj_stored, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    edge_cnt_d = '0;
                    par_err_d  = maj_stored ^ (^shift_q) ^ par_typ_q;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                // Leave half a bit early so a back-to-back start edge is not missed.
                if (edge_cnt_q == half_p1) begin
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                    stp_err_d  = stop_bad;
                    if (!stop_bad && !par_err_q) begin
                        p_data_d = shift_q;
                        dv_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    assign P_DATA     = p_data_q;
    assign data_valid = dv_q;
    assign Par_err    = par_err_q;
    assign Stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed table-driven bench for uart_rx
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       Par_err;
    logic       Stp_err;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .Par_err    (Par_err),
        .Stp_err    (Stp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    int         dv_cnt = 0;
    int         dv_width_err = 0;
    logic       dv_prev = 1'b0;
    logic [7:0] dv_log[$];

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            dv_cnt = dv_cnt + 1;
            dv_log.push_back(P_DATA);
            if (dv_prev) dv_width_err = dv_width_err + 1;
        end
        dv_prev = (data_valid === 1'b1);
    end

    typedef struct {
        logic [7:0] data;
        int         cfg_p;
        int         line_p;
        logic       pe;
        logic       pt;
        logic       pbit;
        logic       sbit;
        logic       exp_dv;
        logic [7:0] exp_pdata;
        logic       exp_par;
        logic       exp_stp;
        logic       exp_par_idle;
        logic       exp_stp_idle;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                              input logic pbit, input logic sbit, input logic glitch);
        int nb;
        logic b;
        nb = pe ? 11 : 10;
        for (int j = 0; j < nb; j++) begin
            if (j == 0)                b = 1'b0;
            else if (j <= 8)           b = d[j-1];
            else if (pe && (j == 9))   b = pbit;
            else                       b = sbit;
            for (int k = 0; k < p; k++) begin
                RX_IN = (glitch && (k == p / 2)) ? ~b : b;
                @(negedge clk);
            end
        end
        RX_IN = 1'b1;
    endtask

    // Waits (from a negedge at which the start bit was driven) to the cycle where the pulse is due.
    task automatic wait_decision(input int t_drop, input int lat);
        while ((cyc - t_drop) < lat) @(negedge clk);
    endtask

    function automatic int latency(input int p, input logic pe);
        return 3 + (9 + int'(pe)) * p + p / 2 + 2;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_drop;
        int dv0;
        int s0;
        int lat;

        vecs[0] = '{8'hA5, 8,  8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 16, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 16, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h01, 16, 16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hC3, 6,  6,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h5A, 4,  8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h96, 32, 32, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_pdata", P_DATA, 8'h00);
        check("reset_dv",    data_valid, 1'b0);
        check("reset_par",   Par_err, 1'b0);
        check("reset_stp",   Stp_err, 1'b0);
        repeat (4) @(negedge clk);

        foreach (vecs[i]) begin
            Prescale = vecs[i].cfg_p[5:0];
            PAR_EN   = vecs[i].pe;
            PAR_TYP  = vecs[i].pt;
            @(negedge clk);
            dv0    = dv_cnt;
            t_drop = cyc;
            lat    = latency(vecs[i].line_p, vecs[i].pe);
            fork
                send_frame(vecs[i].data, vecs[i].line_p, vecs[i].pe, vecs[i].pbit, vecs[i].sbit, 1'b0);
                begin
                    wait_decision(t_drop, lat);
                    check($sformatf("v%0d_dv_at_latency", i), data_valid, vecs[i].exp_dv);
                    check($sformatf("v%0d_pdata", i),         P_DATA,     vecs[i].exp_pdata);
                    check($sformatf("v%0d_par_err", i),       Par_err,    vecs[i].exp_par);
                    check($sformatf("v%0d_stp_err", i),       Stp_err,    vecs[i].exp_stp);
                end
            join
            repeat (3 * vecs[i].line_p) @(negedge clk);
            check($sformatf("v%0d_pulse_count", i), dv_cnt - dv0,  32'(vecs[i].exp_dv));
            check($sformatf("v%0d_par_idle", i),    Par_err,       vecs[i].exp_par_idle);
            check($sformatf("v%0d_stp_idle", i),    Stp_err,       vecs[i].exp_stp_idle);
        end

        // Start glitch of 2 cycles, then a good frame while the config inputs wander mid-frame.
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        @(negedge clk);
        dv0 = dv_cnt;
        RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        RX_IN = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_dv",  dv_cnt - dv0, 0);
        check("glitch_pdata",  P_DATA, 8'h96);
        check("glitch_par",    Par_err, 1'b0);
        check("glitch_stp",    Stp_err, 1'b0);
        dv0    = dv_cnt;
        t_drop = cyc;
        fork
            send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                repeat (12) @(negedge clk);
                Prescale = 6'd20; PAR_EN = 1'b1; PAR_TYP = 1'b1;
            end
            begin
                wait_decision(t_drop, 81);
                check("f55_dv_at_81", data_valid, 1'b1);
                check("f55_pdata",    P_DATA, 8'h55);
            end
        join
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (24) @(negedge clk);
        check("f55_pulse_count", dv_cnt - dv0, 1);

        // Back-to-back frames, P=32, one-cycle glitch at a sample point of every bit.
        Prescale = 6'd32;
        @(negedge clk);
        dv0 = dv_cnt;
        s0  = dv_log.size();
        send_frame(8'h00, 32, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h81, 32, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (64) @(negedge clk);
        check("b2b_pulse_count", dv_cnt - dv0, 3);
        if (dv_log.size() >= s0 + 3) begin
            check("b2b_word0", dv_log[s0],     8'h00);
            check("b2b_word1", dv_log[s0 + 1], 8'hFF);
            check("b2b_word2", dv_log[s0 + 2], 8'h81);
        end else begin
            check("b2b_words_logged", dv_log.size() - s0, 3);
        end

        // Reset in the middle of the data bits.
        Prescale = 6'd8;
        @(negedge clk);
        dv0 = dv_cnt;
        RX_IN = 1'b0;
        repeat (8) @(negedge clk);
        RX_IN = 1'b1;
        repeat (22) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_pdata", P_DATA, 8'h00);
        check("midrst_dv",    data_valid, 1'b0);
        check("midrst_par",   Par_err, 1'b0);
        check("midrst_stp",   Stp_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("midrst_no_dv", dv_cnt - dv0, 0);
        dv0    = dv_cnt;
        t_drop = cyc;
        fork
            send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                wait_decision(t_drop, 81);
                check("f7e_dv_at_81", data_valid, 1'b1);
                check("f7e_pdata",    P_DATA, 8'h7E);
                check("f7e_stp",      Stp_err, 1'b0);
            end
        join
        repeat (24) @(negedge clk);
        check("f7e_pulse_count", dv_cnt - dv0, 1);
        check("dv_single_cycle", dv_width_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
